// File: rtl/alu_if.sv
// Operand/result bundle for the registered adder: x/y in, sum and status flags out.
interface alu_if #(
  parameter int WIDTH = 16
);
  logic [WIDTH-1:0] x;
  logic [WIDTH-1:0] y;
  logic [WIDTH-1:0] sum;
  logic             sign;
  logic             zero;
  logic             carry;
  logic             parity;
  logic             overflow;

  modport master (
    output x, y,
    input  sum, sign, zero, carry, parity, overflow
  );

  modport slave (
    input  x, y,
    output sum, sign, zero, carry, parity, overflow
  );
endinterface

// File: rtl/alu.sv
// Registered two's-complement adder; sum and all status flags load together every edge.
module alu #(
  parameter int WIDTH = 16
) (
  input  logic  clk,
  input  logic  rst,
  alu_if.slave  bus
);
  localparam int MSB = WIDTH - 1;

  logic [WIDTH:0]   w_full;
  logic [WIDTH-1:0] w_sum;
  logic             w_overflow;

  logic [WIDTH-1:0] r_sum;
  logic             r_sign;
  logic             r_zero;
  logic             r_carry;
  logic             r_parity;
  logic             r_overflow;

  always_comb begin
    w_full     = {1'b0, bus.x} + {1'b0, bus.y};
    w_sum      = w_full[WIDTH-1:0];
    // Signed overflow: operands share a sign that the result does not.
    w_overflow = (bus.x[MSB] & bus.y[MSB] & ~w_sum[MSB]) |
                 (~bus.x[MSB] & ~bus.y[MSB] & w_sum[MSB]);
  end

  // Flags are cleared directly on reset, not derived from the cleared sum.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sum      <= '0;
      r_sign     <= 1'b0;
      r_zero     <= 1'b0;
      r_carry    <= 1'b0;
      r_parity   <= 1'b0;
      r_overflow <= 1'b0;
    end else begin
      r_sum      <= w_sum;
      r_sign     <= w_sum[MSB];
      r_zero     <= (w_sum == '0);
      r_carry    <= w_full[WIDTH];
      r_parity   <= ~^w_sum;
      r_overflow <= w_overflow;
    end
  end

  assign bus.sum      = r_sum;
  assign bus.sign     = r_sign;
  assign bus.zero     = r_zero;
  assign bus.carry    = r_carry;
  assign bus.parity   = r_parity;
  assign bus.overflow = r_overflow;
endmodule

// File: tb/tb_alu.sv
// Directed and pipelined checks of alu against an arithmetic reference model via a scoreboard queue.
module tb_alu;
  localparam int WIDTH = 16;

  typedef struct packed {
    logic [WIDTH-1:0] sum;
    logic             sign;
    logic             zero;
    logic             carry;
    logic             parity;
    logic             overflow;
  } res_t;

  logic clk;
  logic rst;
  int unsigned n_checks;
  int unsigned n_fail;
  res_t sb_q[$];

  alu_if #(.WIDTH(WIDTH)) u_if ();

  alu #(.WIDTH(WIDTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (u_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: flags from integer arithmetic, overflow from the signed range.
  function automatic res_t model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                 input logic r);
    res_t m;
    int   ua, ub, us, sa, sb, ss;
    m = '0;
    if (!r) begin
      ua = int'(a);
      ub = int'(b);
      us = ua + ub;
      sa = int'($signed(a));
      sb = int'($signed(b));
      ss = sa + sb;
      m.sum      = us[WIDTH-1:0];
      m.sign     = m.sum[WIDTH-1];
      m.zero     = (us % 65536) == 0;
      m.carry    = us >= 65536;
      m.parity   = ($countones(m.sum) % 2) == 0;
      m.overflow = (ss > 32767) || (ss < -32768);
    end
    return m;
  endfunction

  task automatic chk(input string tag, input logic [WIDTH-1:0] obs, input logic [WIDTH-1:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step(input string tag, input logic r, input logic [WIDTH-1:0] a,
                      input logic [WIDTH-1:0] b);
    res_t e;
    @(negedge clk);
    rst    = r;
    u_if.x = a;
    u_if.y = b;
    sb_q.push_back(model(a, b, r));
    @(posedge clk);
    #1;
    e = sb_q.pop_front();
    chk({tag, ".sum"},      u_if.sum,                     e.sum);
    chk({tag, ".sign"},     {{(WIDTH-1){1'b0}}, u_if.sign},     {{(WIDTH-1){1'b0}}, e.sign});
    chk({tag, ".zero"},     {{(WIDTH-1){1'b0}}, u_if.zero},     {{(WIDTH-1){1'b0}}, e.zero});
    chk({tag, ".carry"},    {{(WIDTH-1){1'b0}}, u_if.carry},    {{(WIDTH-1){1'b0}}, e.carry});
    chk({tag, ".parity"},   {{(WIDTH-1){1'b0}}, u_if.parity},   {{(WIDTH-1){1'b0}}, e.parity});
    chk({tag, ".overflow"}, {{(WIDTH-1){1'b0}}, u_if.overflow}, {{(WIDTH-1){1'b0}}, e.overflow});
  endtask

  initial begin
    logic [WIDTH-1:0] ra;
    logic [WIDTH-1:0] rb;
    n_checks = 0;
    n_fail   = 0;
    rst      = 1'b1;
    u_if.x   = '0;
    u_if.y   = '0;

    step("rst0", 1'b1, 16'h1234, 16'h1111);
    step("rst1", 1'b1, 16'h1234, 16'h1111);
    step("rel",  1'b0, 16'h1234, 16'h1111);
    chk("rel_sum_const", u_if.sum, 16'h2345);
    step("hold", 1'b0, 16'h1234, 16'h1111);
    step("8fff_8000", 1'b0, 16'h8FFF, 16'h8000);
    chk("8fff_par_const", {15'd0, u_if.parity}, 16'h0001);
    step("8000_8000", 1'b0, 16'h8000, 16'h8000);
    chk("8000_zero_const", {15'd0, u_if.zero}, 16'h0001);
    step("8000_0000", 1'b0, 16'h8000, 16'h0000);
    step("7fff_0001", 1'b0, 16'h7FFF, 16'h0001);
    chk("7fff_ovf_const", {15'd0, u_if.overflow}, 16'h0001);
    step("ffff_0001", 1'b0, 16'hFFFF, 16'h0001);
    chk("wrap_sum_const", u_if.sum, 16'h0000);
    step("zero_zero", 1'b0, 16'h0000, 16'h0000);
    step("ffff_ffff", 1'b0, 16'hFFFF, 16'hFFFF);

    for (int i = 0; i < 24; i++) begin
      ra = 16'($urandom);
      rb = 16'($urandom);
      step($sformatf("pipe%0d", i), 1'b0, ra, rb);
    end

    step("rst_mid", 1'b1, 16'h7FFF, 16'h7FFF);
    step("after_rst", 1'b0, 16'h7FFF, 16'h7FFF);

    n_checks++;
    assert (sb_q.size() == 0) else begin
      n_fail++;
      $error("FAIL scoreboard_empty observed=%0d expected=0", sb_q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
